// File: rtl/instruction_fetch.sv
// Sequential instruction fetch front-end. Drives the instruction memory from a PC,
// absorbs its one-cycle read latency and buffers up to two {instr, pc} pairs for the
// decoder over a valid/ready handshake. Branch redirects flush buffered and in-flight
// fetches.
`timescale 1ns/1ps
module instruction_fetch #(
  parameter int unsigned          ADDR_W   = 4,
  parameter int unsigned          DATA_W   = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              discard_q, discard_d;
  logic [1:0]        count_q, count_d;
  // Entry 0 is the head, entry 1 the tail.
  logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;

  logic       pop, push, issue;
  logic [2:0] occupancy;
  logic [1:0] cnt;

  assign mem_addr    = pc_q;
  assign instr       = head_data_q;
  assign instr_pc    = head_pc_q;
  assign instr_valid = (count_q != 2'd0);

  // Handshake, issue decision and next-state for PC, in-flight tracking and the buffer.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    discard_d     = 1'b0;
    count_d       = count_q;
    head_data_d   = head_data_q;
    head_pc_d     = head_pc_q;
    tail_data_d   = tail_data_q;
    tail_pc_d     = tail_pc_q;
    cnt           = count_q;

    pop       = instr_valid & instr_ready;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    // Pop-aware: a slot freed this cycle can already be claimed by a new read.
    issue     = ~branch_valid & (occupancy <= (3'd1 + {2'b00, pop}));
    push      = inflight_q & ~discard_q & ~branch_valid;

    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + ADDR_W'(1);
    end

    if (branch_valid) begin
      pc_d      = branch_target;
      count_d   = 2'd0;
      // Only a read that returns after this edge needs marking; a read returning
      // in the branch cycle itself is already blocked from being pushed.
      discard_d = inflight_d;
    end else begin
      if (pop) begin
        head_data_d = tail_data_q;
        head_pc_d   = tail_pc_q;
        cnt         = cnt - 2'd1;
      end
      if (push) begin
        if (cnt == 2'd0) begin
          head_data_d = mem_data;
          head_pc_d   = inflight_pc_q;
        end else begin
          tail_data_d = mem_data;
          tail_pc_d   = inflight_pc_q;
        end
        cnt = cnt + 2'd1;
      end
      count_d = cnt;
    end
  end

  // State registers with synchronous reset that overrides branches and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
      count_q       <= 2'd0;
      head_data_q   <= '0;
      head_pc_q     <= '0;
      tail_data_q   <= '0;
      tail_pc_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      head_data_q   <= head_data_d;
      head_pc_q     <= head_pc_d;
      tail_data_q   <= tail_data_d;
      tail_pc_q     <= tail_pc_d;
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch front-end that reads the K2 instruction memory and delivers a stream of instructions to the decoder. It drives the 4-bit memory address from a program counter and absorbs the memory's one-cycle registered read latency. A 2-entry buffer presents instructions over a valid/ready handshake. Branch redirects flush in-flight and buffered fetches.

## Interface
- ADDR_W, 4: program counter / memory address width
- DATA_W, 8: instruction width
- RESET_PC, 0: PC value loaded on reset
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- mem_addr  out  ADDR_W  address to instruction memory; sampled by memory at posedge
- mem_data  in  DATA_W  memory read data; valid the cycle after its address was presented
- instr  out  DATA_W  instruction at buffer head
- instr_pc  out  ADDR_W  address the head instruction was fetched from
- instr_valid  out  1  buffer head holds a valid instruction
- instr_ready  in  1  decoder accepts head when high together with instr_valid
- branch_valid  in  1  one-cycle redirect request
- branch_target  in  ADDR_W  new fetch address when branch_valid is high

## Operation
- State:
  - pc register (next address to issue)
  - inflight flag plus inflight_pc (one read outstanding)
  - discard flag (outstanding read is stale)
  - 2-entry FIFO of {instr, pc} with count 0..2
- pop = instr_valid & instr_ready.
- issue = !branch_valid & (count + inflight - pop <= 1).
  - On issue: mem_addr = pc; next cycle inflight=1, inflight_pc=pc, pc=pc+1.
  - Otherwise inflight=0.
  - mem_addr = pc every cycle, so reads are harmless.
- pc increment is modulo 2^ADDR_W: 15 wraps to 0 with no flag and no stall.
- Return cycle (inflight=1 at start of cycle): if discard=0, push {mem_data, inflight_pc} into the FIFO; if discard=1, drop the data.
- Push and pop in the same cycle are both performed; count is unchanged.
- The issue rule guarantees a push never overflows. Overflow is a design error; the bench asserts count ≤ 2.
- instr and instr_pc always show the FIFO head; instr_valid = (count != 0).
- Branch (branch_valid=1):
  - A pop in the same cycle still counts as accepted.
  - All remaining FIFO entries are flushed: count becomes 0 at the next edge.
  - If a read is outstanding, discard is set for the return cycle.
  - pc = branch_target; no issue in the branch cycle.
  - A push arriving in the branch cycle is dropped.
- Back-to-back branches: the last one wins; each suppresses issue in its own cycle.
- No opcode interpretation. The block fetches sequentially forever unless redirected.

## Timing
- Reset (synchronous, dominant over every other input): pc=RESET_PC, count=0, inflight=0, discard=0.
  - Outputs during and after reset: instr_valid=0, instr=0, instr_pc=0, mem_addr=RESET_PC.
- Fetch latency: address issued in cycle T → mem_data in T+1 → written into FIFO at end of T+1 → instr_valid in T+2.
- First cycle after reset deasserts (T0): address RESET_PC is issued; instr_valid=1 in T0+2.
- Throughput: with instr_ready held high, one instruction per cycle from T0+2 onward.
- Stall: instr_ready low → FIFO fills to 2 and issue stops.
  - Instructions are neither lost nor duplicated.
  - Issue resumes in the same cycle that ready is re-asserted (pop-aware rule).
- Branch in cycle B: mem_addr=branch_target in B+1; target instruction instr_valid in B+3.
  - instr_valid=0 in B+1 and B+2.
- Branch during reset: ignored.

## Test plan
- Reset, then ready=1 with memory 0:08,1:19,2:20,3:10,4:70 → instr_valid rises 2 cycles after reset; instr=08,19,20,10,70 on consecutive cycles; instr_pc=0..4.
- ready=0 for 5 cycles starting at the 2nd valid instruction → count saturates at 2 and mem_addr holds; on release the sequence resumes with no gaps, drops or duplicates.
- Run sequentially past address 15 → instr_pc goes 14,15,0,1; data matches memory contents at 0 and 1.
- branch_valid with target 6 while FIFO holds 2 entries and a read is outstanding → stale entries and outstanding data are never presented; next valid instr has instr_pc=6 and data 14, arriving 3 cycles after the branch.
- Branch in the same cycle as a pop, and two branches on consecutive cycles (targets 3 then 8) → the popped instruction is counted once; next valid instr_pc=8.
- Assert reset mid-stream with 2 buffered entries → next cycle instr_valid=0 and mem_addr=0; fetch restarts from 0 with 2-cycle latency.
